data_mem_responder: RTL and testbench

//  Memory-side responder for the processor's load/store port. The core issues one request at a

---
 rtl/data_mem_responder_pkg.sv | 13 +
 rtl/data_mem_responder_ram.sv | 33 +++
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: bus widths and FSM encoding.
package proc_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The array itself is never reset; contents survive a responder reset.
module sp_ram_be
    import proc_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // On an enabled cycle: write the selected bytes and capture the old word for reads.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < BE_W; i++) begin
                if (we_i && be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port: one request at a time,
// WAIT_STATES stall cycles, commit on the edge entering RESP, response held until taken.
module data_mem_responder
    import proc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              latch;

    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [BE_W-1:0]   cur_be;
    logic [31:0]       cur_idx;
    logic              cur_err;
    logic              commit;
    logic [DATA_W-1:0] ram_rdata;

    // With zero wait states the commit happens on the accept edge, so decode must
    // look at the live request in IDLE and at the latched copy afterwards.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_be    = be_q;
        if (state_q == S_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end
        // Unsigned wrap makes addresses below the base land far out of range.
        cur_idx = (cur_addr - BASE_ADDR) >> 2;
        cur_err = (cur_addr[1:0] != 2'b00) || (cur_idx >= 32'(DEPTH_WORDS));
        commit  = ((state_q == S_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                  ((state_q == S_WAIT) && (cnt_q == 4'd1));
    end

    sp_ram_be #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk     (clk),
        .en_i    (commit && !cur_err),
        .we_i    (cur_we),
        .be_i    (cur_be),
        .addr_i  (cur_idx[AW-1:0]),
        .wdata_i (cur_wdata),
        .rdata_o (ram_rdata)
    );

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch     = 1'b0;
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    latch   = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response data is only driven while a load response is being presented.
    always_comb begin
        rsp_err   = (state_q == S_RESP) && cur_err;
        rsp_rdata = '0;
        if ((state_q == S_RESP) && !we_q && !cur_err) rsp_rdata = ram_rdata;
    end

    // State, counter and request capture registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with default parameters (WAIT_STATES=2).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // Drives one request, returns the response fields and the accept-to-response latency.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd, output logic er,
                          output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL store_latency got=%0d exp=3", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL store_rsp got err=%b data=%h exp err=0 data=0", er, rd); end
        do_req(1'b0, 32'h1001_0004, 32'h0, 4'h0, rd, er, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL load_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin failures++; $display("FAIL load_data got=%h err=%b exp=deadbeef err=0", rd, er); end
        // Word 0 and last word are both in range.
        do_req(1'b1, 32'h1001_0000, 32'h0102_0304, 4'hF, rd, er, lat);
        do_req(1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL last_word_store_err got=%b exp=0", er); end
        do_req(1'b0, 32'h1001_0FFC, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin failures++; $display("FAIL last_word_load got=%h err=%b exp=cafef00d err=0", rd, er); end
        do_req(1'b0, 32'h1001_0000, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'h0102_0304) begin failures++; $display("FAIL word0_load got=%h exp=01020304", rd); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h1001_0004, 32'h0000_00AA, 4'b0001, rd, er, lat);
        do_req(1'b0, 32'h1001_0004, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEAA) begin failures++; $display("FAIL be_low_byte got=%h exp=deadbeaa", rd); end
        do_req(1'b1, 32'h1001_0004, 32'h1234_5678, 4'b0000, rd, er, lat);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL be_zero_err got=%b exp=0", er); end
        do_req(1'b0, 32'h1001_0004, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEAA) begin failures++; $display("FAIL be_zero_noop got=%h exp=deadbeaa", rd); end
        do_req(1'b1, 32'h1001_0000, 32'hAB00_CD00, 4'b1010, rd, er, lat);
        do_req(1'b0, 32'h1001_0000, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hAB02_CD04) begin failures++; $display("FAIL be_mixed got=%h exp=ab02cd04", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        logic [31:0] bad [3];
        bad[0] = 32'h1001_0002; bad[1] = 32'h1001_1000; bad[2] = 32'h1000_FFFC;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, bad[i], 32'h0, 4'h0, rd, er, lat);
            checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 3) begin failures++; $display("FAIL err_load_%0d got err=%b data=%h lat=%0d exp err=1 data=0 lat=3", i, er, rd, lat); end
        end
        // Out-of-range stores whose low index bits alias in-range words must not write.
        do_req(1'b1, 32'h1001_1004, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_store_range got=%b exp=1", er); end
        do_req(1'b1, 32'h1001_0006, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_store_misaligned got=%b exp=1", er); end
        do_req(1'b1, 32'h1000_FFFC, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        do_req(1'b0, 32'h1001_0004, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEAA) begin failures++; $display("FAIL err_mem_unchanged got=%h exp=deadbeaa", rd); end
        do_req(1'b0, 32'h1001_0FFC, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL err_last_unchanged got=%h exp=cafef00d", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h1001_0008, 32'h0000_0000, 4'hF, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1001_0004; req_be = 4'h0;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat !== 3) begin failures++; $display("FAIL bp_latency got=%0d exp=3", lat); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEAA || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d got valid=%b data=%h ready=%b exp 1 deadbeaa 0", c, rsp_valid, rsp_rdata, req_ready);
            end
            req_valid = (c % 2 == 0); req_we = 1'b1; req_addr = 32'h1001_0008;
            req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_release got valid=%b ready=%b exp 0 1", rsp_valid, req_ready); end
        do_req(1'b0, 32'h1001_0008, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL bp_ignored_store got=%h exp=0", rd); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1001_0004;
        req_wdata = 32'h1111_1111; req_be = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_in_wait got ready=%b exp=0", req_ready); end
        rst = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_err !== 1'b0) begin failures++; $display("FAIL rst_mid_outputs got valid=%b ready=%b err=%b exp 0 1 0", rsp_valid, req_ready, rsp_err); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_no_rsp got valid=%b exp=0", rsp_valid); end
        do_req(1'b0, 32'h1001_0004, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEAA || er !== 1'b0) begin failures++; $display("FAIL rst_mid_old_data got=%h err=%b exp=deadbeaa err=0", rd, er); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
